// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the 32-entry register array and its write port.
package regfile_pkg;

  localparam int NUM_REGS  = 32;
  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // One-hot decode of a register index; x0 is hardwired, so bit 0 never asserts.
  function automatic logic [NUM_REGS-1:0] onehot32(input reg_idx_t idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    oh[0] = 1'b0;
    return oh;
  endfunction

endpackage

// File: rtl/regwrite_ctrl_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps upward.
// After a grant, ptr moves just past the winner.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N-1:0]     req,
  input  logic             hold,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W:0]   pick_res;

  // Returns {found, index} of the first requester at or after p (wrapping).
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] r, input logic [IDX_W-1:0] p);
    logic [IDX_W:0] res;
    int c;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      c = int'(p) + k;
      if (c >= N) c = c - N;
      if (r[c]) res = {1'b1, IDX_W'(c)};
    end
    return res;
  endfunction

  // Grant decode; hold and reset suppress any grant.
  always_comb begin
    gnt      = '0;
    pick_res = pick(req, ptr);
    gnt_idx  = pick_res[IDX_W-1:0];
    if (resetn && !hold && pick_res[IDX_W]) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  // Pointer advances past the winner only on an actual grant.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (|gnt) begin
      if (gnt_idx == IDX_W'(N - 1)) ptr <= '0;
      else                          ptr <= gnt_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regwrite_ctrl.sv
// Write-port controller for the register array: arbitrates writeback sources,
// launches one registered write per cycle on G/R_in and tracks pending writes.
//
// Handshake: wb_req[i] is a request that stays asserted until accepted; wb_gnt[i]
// is the combinational accept. A request is consumed in the cycle where
// wb_req[i] & wb_gnt[i] is high, and its data/rd are sampled at that edge.
module regwrite_ctrl
  import regfile_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XLEN = regfile_pkg::XLEN
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NREQ-1:0]      wb_req,
  input  logic [NREQ*5-1:0]    wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_gnt,
  input  logic                 wb_hold,
  input  logic                 rsv_valid,
  input  logic [4:0]           rsv_rd,
  input  logic                 flush,
  output logic [XLEN-1:0]      G,
  output logic [NUM_REGS-1:0]  R_in,
  output logic [NUM_REGS-1:0]  pending
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_any;
  reg_idx_t            rd_sel;
  logic [XLEN-1:0]     data_sel;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] pending_nxt;

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req     (wb_req),
    .hold    (wb_hold),
    .gnt     (wb_gnt),
    .gnt_idx (gnt_idx)
  );

  // Select the winner's destination and data; gnt_idx only matters when gnt_any.
  always_comb begin
    gnt_any  = |wb_gnt;
    rd_sel   = wb_rd[gnt_idx*REG_IDX_W +: REG_IDX_W];
    data_sel = wb_data[gnt_idx*XLEN +: XLEN];
  end

  // Scoreboard next state: a same-cycle reserve beats the clear, flush beats both.
  always_comb begin
    set_vec     = rsv_valid ? onehot32(rsv_rd) : '0;
    clr_vec     = gnt_any ? onehot32(rd_sel) : '0;
    pending_nxt = (pending & ~clr_vec) | set_vec;
    if (flush) pending_nxt = '0;
  end

  // Launch register and scoreboard; G keeps its last value on idle cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      G       <= '0;
      R_in    <= '0;
      pending <= '0;
    end else begin
      R_in    <= gnt_any ? onehot32(rd_sel) : '0;
      pending <= pending_nxt;
      if (gnt_any) G <= data_sel;
    end
  end

endmodule

// File: tb/tb_regwrite_ctrl.sv
// Bench for regwrite_ctrl: directed scenarios followed by random traffic,
// all compared against a transaction-level model of the write port.
module tb_regwrite_ctrl;

  localparam int NREQ = 2;
  localparam int XLEN = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 resetn;
  logic [NREQ-1:0]      req;
  logic [4:0]           rd   [NREQ];
  logic [XLEN-1:0]      data [NREQ];
  logic                 hold;
  logic                 rsv_valid;
  logic [4:0]           rsv_rd;
  logic                 flush;

  logic [NREQ*5-1:0]    wb_rd;
  logic [NREQ*XLEN-1:0] wb_data;
  logic [NREQ-1:0]      wb_gnt;
  logic [XLEN-1:0]      G;
  logic [31:0]          R_in;
  logic [31:0]          pending;

  assign wb_rd   = {rd[1], rd[0]};
  assign wb_data = {data[1], data[0]};

  regwrite_ctrl #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .wb_req    (req),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_gnt    (wb_gnt),
    .wb_hold   (hold),
    .rsv_valid (rsv_valid),
    .rsv_rd    (rsv_rd),
    .flush     (flush),
    .G         (G),
    .R_in      (R_in),
    .pending   (pending)
  );

  // scoreboard / reference model state
  int total = 0;
  int bad   = 0;
  logic [XLEN-1:0] exp_q[$];
  int          m_ptr = 0;
  logic [XLEN-1:0] m_G = '0;
  logic [31:0] m_R = '0;
  logic [31:0] m_pend = '0;
  logic [NREQ-1:0] last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check the combinational grant, advance the model at the edge,
  // then check registered outputs just after the edge.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] eg;
    #1;
    g = -1;
    if (resetn && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (g < 0 && req[c]) g = c;
      end
    end
    eg = (g >= 0) ? NREQ'(1 << g) : '0;
    chk("gnt", {62'd0, wb_gnt}, {62'd0, eg});
    last_gnt = wb_gnt;
    @(posedge clk);
    if (!resetn) begin
      m_ptr = 0; m_R = '0; m_pend = '0; m_G = '0;
      exp_q.delete();
    end else begin
      if (g >= 0) begin
        exp_q.push_back(data[g]);
        m_R   = (rd[g] == 5'd0) ? 32'd0 : (32'd1 << rd[g]);
        m_ptr = (g + 1) % NREQ;
        if (rd[g] != 5'd0) m_pend[rd[g]] = 1'b0;
      end else begin
        m_R = '0;
      end
      if (rsv_valid && rsv_rd != 5'd0) m_pend[rsv_rd] = 1'b1;
      if (flush) m_pend = '0;
    end
    #1;
    if (exp_q.size() > 0) m_G = exp_q.pop_front();
    chk("G",       {32'd0, G},       {32'd0, m_G});
    chk("R_in",    {32'd0, R_in},    {32'd0, m_R});
    chk("pending", {32'd0, pending}, {32'd0, m_pend});
  endtask

  // driver helpers
  task automatic idle_inputs();
    req = '0; hold = 1'b0; rsv_valid = 1'b0; rsv_rd = '0; flush = 1'b0;
    rd[0] = '0; rd[1] = '0; data[0] = '0; data[1] = '0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    cycle();
    resetn = 1'b1;
  endtask

  initial begin
    idle_inputs();
    resetn = 1'b0;
    #2;
    // reset state
    do_reset();
    chk("rst_G",    {32'd0, G},       64'd0);
    chk("rst_R",    {32'd0, R_in},    64'd0);
    chk("rst_pend", {32'd0, pending}, 64'd0);

    // single write
    req = 2'b01; rd[0] = 5'd5; data[0] = 32'hDEADBEEF;
    cycle();
    chk("single_gnt", {62'd0, last_gnt}, 64'd1);
    chk("single_G",   {32'd0, G},        64'hDEADBEEF);
    chk("single_R",   {32'd0, R_in},     64'h20);
    req = '0;
    cycle();
    chk("single_R_idle", {32'd0, R_in}, 64'd0);

    // round robin from ptr=0
    do_reset();
    req = 2'b11; rd[0] = 5'd3; rd[1] = 5'd7; data[0] = 32'h1111_0000; data[1] = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_gnt", {62'd0, last_gnt}, (i % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_R",   {32'd0, R_in},     (i % 2 == 0) ? 64'h08 : 64'h80);
    end

    // x0 write and hold
    req = 2'b10; rd[1] = 5'd0;
    cycle();
    chk("x0_gnt", {62'd0, last_gnt}, 64'd2);
    chk("x0_R",   {32'd0, R_in},     64'd0);
    hold = 1'b1; req = 2'b11; rd[1] = 5'd7;
    for (int i = 0; i < 3; i++) cycle();
    hold = 1'b0;
    cycle();
    chk("hold_ptr_kept", {62'd0, last_gnt}, 64'd1);

    // scoreboard race
    req = '0; rsv_valid = 1'b1; rsv_rd = 5'd9;
    cycle();
    chk("rsv9", {63'd0, pending[9]}, 64'd1);
    req = 2'b01; rd[0] = 5'd9;
    cycle();
    chk("race9", {63'd0, pending[9]}, 64'd1);
    rsv_valid = 1'b0; req = 2'b10; rd[1] = 5'd9;
    cycle();
    chk("clr9", {63'd0, pending[9]}, 64'd0);
    req = '0;

    // flush over a same-cycle reserve
    for (int r = 8; r < 12; r++) begin
      rsv_valid = 1'b1; rsv_rd = 5'(r);
      cycle();
    end
    chk("pend_f00", {32'd0, pending}, 64'h0000_0F00);
    flush = 1'b1; rsv_rd = 5'd2;
    cycle();
    chk("flush", {32'd0, pending}, 64'd0);
    flush = 1'b0; rsv_valid = 1'b0;

    // reset mid-stream
    req = 2'b11; rd[0] = 5'd4; rd[1] = 5'd6; data[0] = 32'hA5A5_0001; data[1] = 32'h5A5A_0002;
    cycle();
    resetn = 1'b0;
    cycle();
    chk("midrst_gnt", {62'd0, last_gnt}, 64'd0);
    chk("midrst_G",   {32'd0, G},        64'd0);
    chk("midrst_R",   {32'd0, R_in},     64'd0);
    resetn = 1'b1;
    cycle();
    chk("post_rst_first", {62'd0, last_gnt}, 64'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req       = NREQ'($urandom_range(0, 3));
      rd[0]     = 5'($urandom_range(0, 31));
      rd[1]     = 5'($urandom_range(0, 31));
      data[0]   = $urandom;
      data[1]   = $urandom;
      hold      = ($urandom_range(0, 7) == 0);
      rsv_valid = ($urandom_range(0, 1) == 1);
      rsv_rd    = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 15) == 0);
      resetn    = ($urandom_range(0, 49) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
